// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the two-port memory arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
    typedef enum logic {GNT_IF, GNT_D} gnt_t;
    localparam logic [31:0] DEF_ERR_DATA = 32'hDEADBEEF;
endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: 2-way round-robin picker; on a tie the port not granted last wins
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic req_if,
    input  logic req_d,
    input  gnt_t last_grant,
    output gnt_t grant
);
    always_comb begin
        grant = (req_if && req_d) ? ((last_grant == GNT_IF) ? GNT_D : GNT_IF)
                                  : (req_d ? GNT_D : GNT_IF);
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory between the fetch port and the data port,
// one access at a time, with busy handshake, timeout and registered read data.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = DEF_ERR_DATA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    output logic        if_stall,
    input  logic        d_re,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_re,
    output logic [3:0]  mem_we,
    input  logic [31:0] mem_rdata,
    input  logic        mem_busy,
    output logic        bus_err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state, state_nxt;
    gnt_t          gnt, last_grant, pick;
    logic [CW-1:0] cnt;
    logic          is_rd, d_wr, d_req, any_req, done;

    assign d_wr     = |d_we;
    assign d_req    = d_re | d_wr;
    assign any_req  = if_req | d_req;
    assign if_stall = if_req & ~if_ack;
    assign d_stall  = d_req & ~d_ack;
    // In WAIT, completion wins over timeout when both happen in the same cycle
    assign done     = (state == WAIT) && (!mem_busy || cnt == CW'(TIMEOUT));

    mem_arb_rr u_rr (
        .req_if     (if_req),
        .req_d      (d_req),
        .last_grant (last_grant),
        .grant      (pick)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = any_req ? ISSUE : IDLE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = done ? ACK : WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            gnt        <= GNT_IF;
            last_grant <= GNT_IF;
            cnt        <= '0;
            is_rd      <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_re     <= 1'b0;
            mem_we     <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            state   <= state_nxt;
            mem_re  <= 1'b0;
            mem_we  <= '0;
            if_ack  <= 1'b0;
            d_ack   <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                IDLE: if (any_req) begin
                    gnt        <= pick;
                    last_grant <= pick;
                    mem_addr   <= (pick == GNT_D) ? d_addr : if_addr;
                    mem_wdata  <= (pick == GNT_D) ? d_wdata : mem_wdata;
                    mem_we     <= (pick == GNT_D) ? d_we : 4'b0000;
                    mem_re     <= (pick == GNT_IF) || !d_wr;
                    is_rd      <= (pick == GNT_IF) || !d_wr;
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    if (!done) cnt <= cnt + 1'b1;
                    if (done) begin
                        if_ack  <= (gnt == GNT_IF);
                        d_ack   <= (gnt == GNT_D);
                        bus_err <= mem_busy;
                        if (is_rd && gnt == GNT_IF) if_rdata <= mem_busy ? ERR_DATA : mem_rdata;
                        if (is_rd && gnt == GNT_D)  d_rdata  <= mem_busy ? ERR_DATA : mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant order, latency, writes, timeout and reset
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0, if_ack, if_stall;
    logic [31:0] if_addr = '0, if_rdata;
    logic        d_re = 1'b0, d_ack, d_stall;
    logic [3:0]  d_we = '0;
    logic [31:0] d_addr = '0, d_wdata = '0, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic        mem_re, mem_busy = 1'b0, bus_err;
    logic [3:0]  mem_we;
    int          n_vec = 0, n_err = 0;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .if_stall  (if_stall),
        .d_re      (d_re),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .d_stall   (d_stall),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_busy  (mem_busy),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_re", 32'(mem_re), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_if_ack", 32'(if_ack), 0);
        chk("rst_d_ack", 32'(d_ack), 0);
        chk("rst_bus_err", 32'(bus_err), 0);
        rst = 1'b1;
        // fetch-only minimum latency
        if_req = 1'b1; if_addr = 32'h100; mem_rdata = 32'h8C220004;
        #1 chk("t1_stall_c0", 32'(if_stall), 1);
        cyc;
        chk("t1_mem_re_c1", 32'(mem_re), 1);
        chk("t1_mem_addr", mem_addr, 32'h100);
        chk("t1_mem_we_c1", 32'(mem_we), 0);
        chk("t1_stall_c1", 32'(if_stall), 1);
        cyc;
        chk("t1_mem_re_c2", 32'(mem_re), 0);
        chk("t1_ack_c2", 32'(if_ack), 0);
        chk("t1_stall_c2", 32'(if_stall), 1);
        cyc;
        chk("t1_ack_c3", 32'(if_ack), 1);
        chk("t1_rdata", if_rdata, 32'h8C220004);
        chk("t1_stall_c3", 32'(if_stall), 0);
        chk("t1_d_ack_c3", 32'(d_ack), 0);
        if_req = 1'b0;
        cyc;
        chk("t1_ack_c4", 32'(if_ack), 0);
        // byte write
        d_we = 4'b0100; d_addr = 32'h2002; d_wdata = 32'hABABABAB;
        #1 chk("t2_d_stall", 32'(d_stall), 1);
        cyc;
        chk("t2_mem_we_issue", 32'(mem_we), 32'h4);
        chk("t2_mem_re_issue", 32'(mem_re), 0);
        chk("t2_mem_addr", mem_addr, 32'h2002);
        chk("t2_mem_wdata", mem_wdata, 32'hABABABAB);
        cyc;
        chk("t2_mem_we_wait", 32'(mem_we), 0);
        cyc;
        chk("t2_d_ack", 32'(d_ack), 1);
        chk("t2_d_rdata_kept", d_rdata, 32'h0);
        chk("t2_bus_err", 32'(bus_err), 0);
        d_we = 4'b0000;
        cyc;
        chk("t2_d_ack_off", 32'(d_ack), 0);
        // ties out of reset alternate D, IF, D, IF
        rst = 1'b0;
        cyc;
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h500; d_re = 1'b1; d_addr = 32'h600;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc;
            mem_rdata = 32'hA0000000 + 32'(i);
            cyc;
            chk("t3_grant_addr", mem_addr, (i % 2 == 0) ? 32'h600 : 32'h500);
            chk("t3_mem_re", 32'(mem_re), 1);
            cyc;
            cyc;
            chk("t3_d_ack", 32'(d_ack), (i % 2 == 0) ? 1 : 0);
            chk("t3_if_ack", 32'(if_ack), (i % 2 == 0) ? 0 : 1);
            if (i % 2 == 0) begin
                chk("t3_d_rdata", d_rdata, 32'hA0000000 + 32'(i));
                chk("t3_if_stall_loser", 32'(if_stall), 1);
            end else begin
                chk("t3_if_rdata", if_rdata, 32'hA0000000 + 32'(i));
                chk("t3_d_stall_loser", 32'(d_stall), 1);
            end
        end
        if_req = 1'b0; d_re = 1'b0;
        cyc;
        // timeout with TIMEOUT=4: ack 5 cycles after WAIT entry
        d_re = 1'b1; d_addr = 32'h700; mem_busy = 1'b1;
        cyc;
        chk("t4_mem_re", 32'(mem_re), 1);
        cyc;
        for (int k = 1; k <= 4; k++) begin
            cyc;
            chk("t4_no_ack_yet", 32'(d_ack), 0);
        end
        cyc;
        chk("t4_d_ack", 32'(d_ack), 1);
        chk("t4_bus_err", 32'(bus_err), 1);
        chk("t4_err_data", d_rdata, 32'hDEADBEEF);
        d_re = 1'b0;
        cyc;
        chk("t4_bus_err_off", 32'(bus_err), 0);
        // reset during WAIT abandons the access
        if_req = 1'b1; if_addr = 32'h800;
        cyc;
        chk("t5_issue_addr", mem_addr, 32'h800);
        cyc;
        d_re = 1'b1; d_addr = 32'h900; rst = 1'b0;
        #1;
        chk("t5_rst_mem_re", 32'(mem_re), 0);
        chk("t5_rst_mem_we", 32'(mem_we), 0);
        chk("t5_rst_mem_addr", mem_addr, 32'h0);
        chk("t5_rst_if_ack", 32'(if_ack), 0);
        cyc;
        rst = 1'b1; mem_busy = 1'b0; mem_rdata = 32'h5555AAAA;
        chk("t5_no_ack_after", 32'(if_ack), 0);
        cyc;
        chk("t5_rearb_d_first", mem_addr, 32'h900);
        cyc;
        cyc;
        chk("t5_d_ack", 32'(d_ack), 1);
        chk("t5_if_ack", 32'(if_ack), 0);
        chk("t5_d_rdata", d_rdata, 32'h5555AAAA);
        d_re = 1'b0; mem_rdata = 32'h12345678;
        // held fetch follows; two busy cycles stretch latency by two
        cyc;
        cyc;
        chk("t6_issue_addr", mem_addr, 32'h800);
        mem_busy = 1'b1;
        cyc;
        chk("t6_ack_w0", 32'(if_ack), 0);
        cyc;
        chk("t6_ack_w1", 32'(if_ack), 0);
        cyc;
        chk("t6_ack_w2", 32'(if_ack), 0);
        mem_busy = 1'b0;
        cyc;
        chk("t6_ack", 32'(if_ack), 1);
        chk("t6_rdata", if_rdata, 32'h12345678);
        chk("t6_bus_err", 32'(bus_err), 0);
        if_req = 1'b0;
        cyc;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
